l2_ip_sequencer: RTL and testbench

- Sits directly upstream of the IPv4 header parser on the 64-bit packet bus.
- Walks the Ethernet/VLAN header of every packet and finds where the L3 header begins.
- Drives the parser's IP-enable and 2-byte/6-byte alignment controls, word-aligned with a one-cycle registered copy of the packet stream.
- Also reports L3 class and VLAN tag count, so downstream parsers stay idle on non-IPv4 traffic.

---
 rtl/l2_seq_pkg.sv | 25 ++
 rtl/l2_ip_sequencer_if.sv | 11 +
 rtl/l2_ethertype_dec.sv | 21 ++
 rtl/l2_ip_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_l2_ip_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/l2_seq_pkg.sv
// Ethertype/TPID constants and shared enums for the L2 header walker feeding the IPv4 parser.
package l2_seq_pkg;

    localparam logic [15:0] ETH_IPV4  = 16'h0800;
    localparam logic [15:0] ETH_IPV6  = 16'h86DD;
    localparam logic [15:0] TPID_8100 = 16'h8100;
    localparam logic [15:0] TPID_88A8 = 16'h88A8;
    localparam logic [15:0] TPID_9100 = 16'h9100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TYPE_HI,
        ST_TYPE_LO,
        ST_L3_IP,
        ST_L3_SKIP
    } seq_state_t;

    typedef enum logic [1:0] {
        L3_NONE  = 2'd0,
        L3_IPV4  = 2'd1,
        L3_IPV6  = 2'd2,
        L3_OTHER = 2'd3
    } l3_class_t;

endpackage

// File: rtl/l2_ip_sequencer_if.sv
// 64-bit packet word bus: data, valid-byte count, sop/eop framing and word strobe.
interface l2_ip_sequencer_if;
    logic [63:0] data;
    logic [2:0]  mod;
    logic        sop;
    logic        eop;
    logic        en;

    modport master (output data, mod, sop, eop, en);
    modport slave  (input  data, mod, sop, eop, en);
endinterface

// File: rtl/l2_ethertype_dec.sv
// Combinational 16-bit ethertype classifier; no latency, no flow control.
// TPID set widens to 0x88A8/0x9100 when L2_SEQ_QINQ_EN is defined.
module l2_ethertype_dec
    import l2_seq_pkg::*;
(
    input  logic [15:0] etype,
    output logic        is_tpid,
    output logic        is_ipv4,
    output logic        is_ipv6
);

    assign is_ipv4 = (etype == ETH_IPV4);
    assign is_ipv6 = (etype == ETH_IPV6);

`ifdef L2_SEQ_QINQ_EN
    assign is_tpid = (etype == TPID_8100) || (etype == TPID_88A8) || (etype == TPID_9100);
`else
    assign is_tpid = (etype == TPID_8100);
`endif

endmodule

// File: rtl/l2_ip_sequencer.sv
// Walks Ethernet/VLAN headers and drives IPv4-parser controls; 1-cycle registered latency.
// No backpressure: words gated only by pkt_in.en. Stacked tags need L2_SEQ_QINQ_EN.
module l2_ip_sequencer
    import l2_seq_pkg::*;
#(
    parameter int max_vlan_p = 2
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              en_i,
    l2_ip_sequencer_if.slave  pkt_in,
    l2_ip_sequencer_if.master pkt_out,
    output logic              ip_en_o,
    output logic              ip_6b_n2b_start_o,
    output logic [1:0]        l3_class_o,
    output logic              l3_class_en_o,
    output logic [2:0]        vlan_cnt_o,
    output logic              hdr_err_o
);

`ifdef L2_SEQ_QINQ_EN
    localparam int max_tags = max_vlan_p;
`else
    localparam int max_tags = (max_vlan_p < 1) ? max_vlan_p : 1;
`endif
    localparam logic [2:0] tag_limit = 3'(max_tags);

    seq_state_t  state_q, state_d, w_state, hi_state;
    l3_class_t   class_q, w_class, hi_class;
    logic [2:0]  cnt_q, w_cnt, hi_cnt, hi_cnt_in;
    logic        b6_q, w_b6, hi_b6;
    logic        hi_err, w_err, runt;
    logic        t0_tpid, t0_ipv4, t0_ipv6;
    logic        t4_tpid, t4_ipv4, t4_ipv6;
    logic [63:0] data_q;
    logic [2:0]  mod_q;
    logic        sop_q, eop_q, en_q;

    l2_ethertype_dec u_dec_off0 (
        .etype   (pkt_in.data[63:48]),
        .is_tpid (t0_tpid),
        .is_ipv4 (t0_ipv4),
        .is_ipv6 (t0_ipv6)
    );

    l2_ethertype_dec u_dec_off4 (
        .etype   (pkt_in.data[31:16]),
        .is_tpid (t4_tpid),
        .is_ipv4 (t4_ipv4),
        .is_ipv6 (t4_ipv6)
    );

    // Offset-4 rules; in TYPE_LO they apply only after an offset-0 tag, hence the pre-incremented count.
    always_comb begin
        hi_cnt_in = (state_q == ST_TYPE_LO) ? cnt_q + 3'd1 : cnt_q;
        hi_state  = ST_L3_SKIP;
        hi_class  = L3_OTHER;
        hi_cnt    = hi_cnt_in;
        hi_b6     = 1'b0;
        hi_err    = 1'b0;
        if (t4_ipv4) begin
            hi_state = ST_L3_IP;
            hi_class = L3_IPV4;
            hi_b6    = 1'b1;
        end else if (t4_tpid) begin
            if (hi_cnt_in == tag_limit) begin
                hi_err = 1'b1;
            end else begin
                hi_state = ST_TYPE_LO;
                hi_class = L3_NONE;
                hi_cnt   = hi_cnt_in + 3'd1;
            end
        end else if (t4_ipv6) begin
            hi_class = L3_IPV6;
        end
    end

    always_comb begin
        w_state = state_q;
        w_class = class_q;
        w_cnt   = cnt_q;
        w_b6    = b6_q;
        w_err   = 1'b0;
        runt    = 1'b0;
        if (pkt_in.sop) begin
            w_err   = (state_q != ST_IDLE);
            w_state = ST_TYPE_HI;
            w_class = L3_NONE;
            w_cnt   = '0;
            w_b6    = 1'b0;
            if (pkt_in.eop) begin
                runt    = 1'b1;
                w_err   = 1'b1;
                w_class = L3_OTHER;
            end
        end else begin
            case (state_q)
                ST_TYPE_HI: begin
                    if (pkt_in.eop) begin
                        runt    = 1'b1;
                        w_err   = 1'b1;
                        w_class = L3_OTHER;
                    end else begin
                        w_state = hi_state;
                        w_class = hi_class;
                        w_cnt   = hi_cnt;
                        w_b6    = hi_b6;
                        w_err   = hi_err;
                    end
                end
                ST_TYPE_LO: begin
                    if (pkt_in.eop) begin
                        runt    = 1'b1;
                        w_err   = 1'b1;
                        w_class = L3_OTHER;
                    end else if (t0_ipv4) begin
                        w_state = ST_L3_IP;
                        w_class = L3_IPV4;
                        w_b6    = 1'b0;
                    end else if (t0_tpid) begin
                        if (cnt_q == tag_limit) begin
                            w_state = ST_L3_SKIP;
                            w_class = L3_OTHER;
                            w_err   = 1'b1;
                        end else begin
                            w_state = hi_state;
                            w_class = hi_class;
                            w_cnt   = hi_cnt;
                            w_b6    = hi_b6;
                            w_err   = hi_err;
                        end
                    end else begin
                        w_state = ST_L3_SKIP;
                        w_class = t0_ipv6 ? L3_IPV6 : L3_OTHER;
                    end
                end
                default: ;
            endcase
        end
        state_d = pkt_in.eop ? ST_IDLE : w_state;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= ST_IDLE;
        end else if (pkt_in.en) begin
            state_q <= state_d;
        end
    end

    // Context is cleared on eop so idle words without sop report all-zero status.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            class_q <= L3_NONE;
            cnt_q   <= '0;
            b6_q    <= 1'b0;
        end else if (pkt_in.en) begin
            if (pkt_in.eop) begin
                class_q <= L3_NONE;
                cnt_q   <= '0;
                b6_q    <= 1'b0;
            end else begin
                class_q <= w_class;
                cnt_q   <= w_cnt;
                b6_q    <= w_b6;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            data_q            <= '0;
            mod_q             <= '0;
            sop_q             <= 1'b0;
            eop_q             <= 1'b0;
            en_q              <= 1'b0;
            ip_en_o           <= 1'b0;
            ip_6b_n2b_start_o <= 1'b0;
            l3_class_o        <= L3_NONE;
            l3_class_en_o     <= 1'b0;
            vlan_cnt_o        <= '0;
            hdr_err_o         <= 1'b0;
        end else begin
            en_q      <= pkt_in.en;
            hdr_err_o <= 1'b0;
            if (pkt_in.en) begin
                data_q            <= pkt_in.data;
                mod_q             <= pkt_in.mod;
                sop_q             <= pkt_in.sop;
                eop_q             <= pkt_in.eop;
                ip_en_o           <= en_i && (w_state == ST_L3_IP);
                ip_6b_n2b_start_o <= en_i && w_b6;
                l3_class_o        <= en_i ? w_class : L3_NONE;
                l3_class_en_o     <= en_i && (runt || w_state == ST_L3_IP || w_state == ST_L3_SKIP);
                vlan_cnt_o        <= en_i ? w_cnt : 3'd0;
                hdr_err_o         <= en_i && w_err;
            end
        end
    end

    assign pkt_out.data = data_q;
    assign pkt_out.mod  = mod_q;
    assign pkt_out.sop  = sop_q;
    assign pkt_out.eop  = eop_q;
    assign pkt_out.en   = en_q;

endmodule

// File: tb/tb_l2_ip_sequencer.sv
// Directed bench for l2_ip_sequencer: hand-computed status per output word, 1-cycle latency.
module tb_l2_ip_sequencer;

    logic       clk = 1'b0;
    logic       srst;
    logic       en;
    logic       ip_en, b6, cls_en, err;
    logic [1:0] cls;
    logic [2:0] vlan;
    int         tests = 0;
    int         fails = 0;

`ifdef L2_SEQ_QINQ_EN
    localparam bit qinq = 1'b1;
`else
    localparam bit qinq = 1'b0;
`endif

    localparam logic [63:0] W0    = 64'h0011_2233_4455_0066;
    localparam logic [63:0] W_V4  = 64'h7788_99AA_0800_4500;
    localparam logic [63:0] W_T1  = 64'h7788_99AA_8100_0064;
    localparam logic [63:0] W_IP2 = 64'h0800_4500_0054_0000;
    localparam logic [63:0] W_PAY = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] W_QQ1 = 64'h7788_99AA_88A8_0064;
    localparam logic [63:0] W_QQ2 = 64'h8100_0065_0800_4500;
    localparam logic [63:0] W_3T2 = 64'h8100_0065_8100_0066;
    localparam logic [63:0] W_V6  = 64'h7788_99AA_86DD_6000;

    always #5 clk = ~clk;

    l2_ip_sequencer_if in_if ();
    l2_ip_sequencer_if out_if ();

    l2_ip_sequencer #(.max_vlan_p(2)) dut (
        .clk_i             (clk),
        .srst_i            (srst),
        .en_i              (en),
        .pkt_in            (in_if),
        .pkt_out           (out_if),
        .ip_en_o           (ip_en),
        .ip_6b_n2b_start_o (b6),
        .l3_class_o        (cls),
        .l3_class_en_o     (cls_en),
        .vlan_cnt_o        (vlan),
        .hdr_err_o         (err)
    );

    function automatic logic [8:0] st(input logic i, input logic s6, input logic [1:0] c,
                                      input logic ce, input logic [2:0] v, input logic e);
        return {i, s6, c, ce, v, e};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic word(input string tag, input logic [63:0] d, input logic sop,
                        input logic eop, input logic [8:0] exp);
        logic [2:0] m;
        m = eop ? 3'd6 : 3'd0;
        in_if.data = d;
        in_if.sop  = sop;
        in_if.eop  = eop;
        in_if.mod  = m;
        in_if.en   = 1'b1;
        @(posedge clk); #1;
        check({tag, "/st"}, 128'({out_if.en, ip_en, b6, cls, cls_en, vlan, err}), 128'({1'b1, exp}));
        check({tag, "/dat"}, 128'({out_if.data, out_if.mod, out_if.sop, out_if.eop}), 128'({d, m, sop, eop}));
    endtask

    task automatic gap(input string tag, input int n, input logic [8:0] held);
        in_if.en  = 1'b0;
        in_if.sop = 1'b0;
        in_if.eop = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check(tag, 128'({out_if.en, ip_en, b6, cls, cls_en, vlan, err}), 128'({1'b0, held[8:1], 1'b0}));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] z, v4, t1p, t1, q1, q2, ov, v6;
        logic [2:0] vc;
        z   = st(0, 0, 2'd0, 0, 3'd0, 0);
        v4  = st(1, 1, 2'd1, 1, 3'd0, 0);
        t1p = st(0, 0, 2'd0, 0, 3'd1, 0);
        t1  = st(1, 0, 2'd1, 1, 3'd1, 0);
        q1  = qinq ? st(0, 0, 2'd0, 0, 3'd1, 0) : st(0, 0, 2'd3, 1, 3'd0, 0);
        q2  = qinq ? st(1, 1, 2'd1, 1, 3'd2, 0) : st(0, 0, 2'd3, 1, 3'd0, 0);
        vc  = qinq ? 3'd2 : 3'd1;
        ov  = st(0, 0, 2'd3, 1, vc, 1);
        v6  = st(0, 0, 2'd2, 1, 3'd0, 0);

        srst = 1'b1;
        en   = 1'b1;
        in_if.data = '0;
        in_if.mod  = '0;
        in_if.sop  = 1'b0;
        in_if.eop  = 1'b0;
        in_if.en   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 128'({out_if.en, out_if.data, out_if.mod, out_if.sop, out_if.eop,
                             ip_en, b6, cls, cls_en, vlan, err}), 128'(0));
        srst = 1'b0;

        // untagged IPv4
        word("u0", W0, 1, 0, z);
        word("u1", W_V4, 0, 0, v4);
        word("u2", W_PAY, 0, 0, v4);
        word("u3", W_PAY, 0, 1, v4);
        word("u_idle", W_PAY, 0, 0, z);

        // single 0x8100 tag
        word("t0", W0, 1, 0, z);
        word("t1", W_T1, 0, 0, t1p);
        word("t2", W_IP2, 0, 0, t1);
        word("t3", W_PAY, 0, 1, t1);

        // 0x88A8 + 0x8100
        word("q0", W0, 1, 0, z);
        word("q1", W_QQ1, 0, 0, q1);
        word("q2", W_QQ2, 0, 0, q2);
        word("q3", W_PAY, 0, 1, q2);

        // three 0x8100 tags: overflow
        word("s0", W0, 1, 0, z);
        word("s1", W_T1, 0, 0, t1p);
        word("s2", W_3T2, 0, 0, ov);
        word("s3", W_IP2, 0, 1, {ov[8:1], 1'b0});
        word("n0", W0, 1, 0, z);
        word("n1", W_V4, 0, 0, v4);
        word("n2", W_PAY, 0, 1, v4);

        // runt, then sop without eop, then gapped tagged header
        word("r0", W0, 1, 1, st(0, 0, 2'd3, 1, 3'd0, 1));
        word("a0", W0, 1, 0, z);
        word("a1", W_V4, 0, 0, v4);
        word("a2", W0, 1, 0, st(0, 0, 2'd0, 0, 3'd0, 1));
        gap("g1", 1, z);
        word("a3", W_T1, 0, 0, t1p);
        gap("g2", 3, t1p);
        word("a4", W_IP2, 0, 0, t1);
        gap("g3", 2, t1);
        word("a5", W_PAY, 0, 1, t1);

        // IPv6
        word("v0", W0, 1, 0, z);
        word("v1", W_V6, 0, 0, v6);
        word("v2", W_PAY, 0, 1, v6);

        // synchronous reset on word 2 of an IPv4 packet
        word("x0", W0, 1, 0, z);
        word("x1", W_V4, 0, 0, v4);
        in_if.data = W_PAY;
        in_if.sop  = 1'b0;
        in_if.eop  = 1'b0;
        in_if.en   = 1'b1;
        srst       = 1'b1;
        @(posedge clk); #1;
        check("x2_srst", 128'({out_if.en, out_if.data, ip_en, b6, cls, cls_en, vlan, err}), 128'(0));
        srst = 1'b0;
        word("x3", W_PAY, 0, 0, z);
        word("x4", W_PAY, 0, 1, z);

        // block enable dropped mid-packet
        word("e0", W0, 1, 0, z);
        word("e1", W_V4, 0, 0, v4);
        en = 1'b0;
        word("e2", W_PAY, 0, 0, z);
        word("e3", W_PAY, 0, 1, z);
        en = 1'b1;
        word("e4", W_PAY, 0, 0, z);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
